wptr_full: RTL and testbench

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/fifo_pkg.sv | 12 +
 rtl/gray2bin.sv | 17 +
 rtl/wptr_full.sv | 70 +++++++
 tb/tb_wptr_full.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer defaults and binary-to-Gray helper
package fifo_pkg;

    localparam int ASIZE_DEF = 4;
    // Widest pointer supported (ASIZE up to 12, plus the wrap bit)
    localparam int GRAY_W    = 13;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter, width W
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] GRAY,
    output logic [W-1:0] BIN
);

    // Each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        BIN = '0;
        for (int i = 0; i < W; i++) begin
            BIN[i] = ^(GRAY >> i);
        end
    end

endmodule

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - async FIFO write pointer, full/almost-full, occupancy and overflow
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ASIZE    = ASIZE_DEF,
    parameter int AF_LEVEL = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WINC,
    input  logic             OVF_CLR,
    input  logic [ASIZE:0]   WQ2_RPTR,
    output logic [ASIZE-1:0] WADDR,
    output logic [ASIZE:0]   WPTR,
    output logic             WFULL,
    output logic [ASIZE:0]   WCOUNT,
    output logic             ALMOST_FULL,
    output logic             OVERFLOW
);

    localparam logic [ASIZE:0] AF_THR = (ASIZE+1)'(AF_LEVEL);

    logic [ASIZE:0]      wbin;
    logic [ASIZE:0]      wbin_next;
    logic [ASIZE:0]      rbin;
    logic [ASIZE:0]      occ_next;
    logic [ASIZE:0]      rptr_full;
    logic [GRAY_W-1:0]   wgray_wide;
    logic                wfull_next;

    gray2bin #(.W(ASIZE+1)) u_gray2bin (
        .GRAY (WQ2_RPTR),
        .BIN  (rbin)
    );

    // Full when the next write pointer equals the read pointer one lap ahead:
    // in Gray code that is the top two bits inverted, the rest equal.
    always_comb begin
        wbin_next  = wbin + {{ASIZE{1'b0}}, WINC & ~WFULL};
        wgray_wide = bin2gray(GRAY_W'(wbin_next));
        rptr_full  = {~WQ2_RPTR[ASIZE:ASIZE-1], WQ2_RPTR[ASIZE-2:0]};
        wfull_next = (wgray_wide == GRAY_W'(rptr_full));
        occ_next   = wbin_next - rbin;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbin        <= '0;
            WPTR        <= '0;
            WFULL       <= 1'b0;
            WCOUNT      <= '0;
            ALMOST_FULL <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            WPTR        <= wgray_wide[ASIZE:0];
            WFULL       <= wfull_next;
            WCOUNT      <= occ_next;
            ALMOST_FULL <= (occ_next >= AF_THR);
            if (WINC && WFULL) begin
                OVERFLOW <= 1'b1;
            end else if (OVF_CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

    assign WADDR = wbin[ASIZE-1:0];

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - randomized self-checking bench for wptr_full against an occupancy model
module tb_wptr_full;

    localparam int ASIZE    = 4;
    localparam int AF_LEVEL = 12;
    localparam int DEPTH    = 1 << ASIZE;
    localparam int PMOD     = 2 * DEPTH;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             WINC = 1'b0;
    logic             OVF_CLR = 1'b0;
    logic [ASIZE:0]   WQ2_RPTR = '0;
    logic [ASIZE-1:0] WADDR;
    logic [ASIZE:0]   WPTR;
    logic             WFULL;
    logic [ASIZE:0]   WCOUNT;
    logic             ALMOST_FULL;
    logic             OVERFLOW;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: total accepted writes and reads (mod 2*DEPTH) plus the sticky flag
    int m_w;
    int m_r;
    int m_occ;
    bit m_full;
    bit m_ovf;

    wptr_full #(.ASIZE(ASIZE), .AF_LEVEL(AF_LEVEL)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WINC        (WINC),
        .OVF_CLR     (OVF_CLR),
        .WQ2_RPTR    (WQ2_RPTR),
        .WADDR       (WADDR),
        .WPTR        (WPTR),
        .WFULL       (WFULL),
        .WCOUNT      (WCOUNT),
        .ALMOST_FULL (ALMOST_FULL),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic int to_gray(input int x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wptr"},   int'(WPTR),        to_gray(m_w));
        chk({tag, ".waddr"},  int'(WADDR),       m_w % DEPTH);
        chk({tag, ".wfull"},  int'(WFULL),       int'(m_full));
        chk({tag, ".wcount"}, int'(WCOUNT),      m_occ);
        chk({tag, ".af"},     int'(ALMOST_FULL), int'(m_occ >= AF_LEVEL));
        chk({tag, ".ovf"},    int'(OVERFLOW),    int'(m_ovf));
    endtask

    task automatic model_reset();
        m_w = 0; m_r = 0; m_occ = 0; m_full = 0; m_ovf = 0;
    endtask

    // Drive inputs just after an edge, clock one edge, update model, check
    task automatic step(input logic winc, input logic clr, input string tag);
        bit accept;
        WINC     = winc;
        OVF_CLR  = clr;
        WQ2_RPTR = (ASIZE+1)'(to_gray(m_r));
        @(posedge CLK);
        accept = winc && !m_full;
        if (winc && m_full) m_ovf = 1;
        else if (clr)       m_ovf = 0;
        m_w    = (m_w + int'(accept)) % PMOD;
        m_occ  = (m_w - m_r + PMOD) % PMOD;
        m_full = (m_occ == DEPTH);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        RST = 1'b1;
        model_reset();
        WQ2_RPTR = '0;
        #1;
        check_all(tag);
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        RST = 1'b1;
        #1;
        check_all("reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, "fill");
            if (i == AF_LEVEL - 1) chk("af_before", int'(ALMOST_FULL), 0);
            if (i == AF_LEVEL)     chk("af_at",     int'(ALMOST_FULL), 1);
        end
        chk("fill.wfull",  int'(WFULL),  1);
        chk("fill.wptr",   int'(WPTR),   'b11000);
        chk("fill.wcount", int'(WCOUNT), 16);
        chk("fill.waddr",  int'(WADDR),  0);
        step(1'b1, 1'b0, "ovf");
        chk("ovf.wptr", int'(WPTR),     'b11000);
        chk("ovf.set",  int'(OVERFLOW), 1);
        step(1'b1, 1'b1, "ovf_prio");
        chk("ovf_prio", int'(OVERFLOW), 1);
        step(1'b0, 1'b1, "ovf_clr");
        chk("ovf_clr", int'(OVERFLOW), 0);

        // Reader catches up in one jump, writer laps the pointer space
        m_r = DEPTH;
        step(1'b0, 1'b0, "rjump");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, "wrap");
        chk("wrap.wptr",   int'(WPTR),   0);
        chk("wrap.wfull",  int'(WFULL),  1);
        chk("wrap.wcount", int'(WCOUNT), 16);

        m_r = (m_r + 1) % PMOD;
        step(1'b1, 1'b0, "simul");
        chk("simul.blocked", int'(WPTR),  0);
        chk("simul.wfull",   int'(WFULL), 0);
        step(1'b1, 1'b0, "simul_next");
        chk("simul_next.wptr",  int'(WPTR),  to_gray(1));
        chk("simul_next.wfull", int'(WFULL), 1);

        async_reset("reset2");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "pre_rst");
        chk("pre_rst.wcount", int'(WCOUNT), 7);
        async_reset("mid_rst");
        chk("mid_rst.wcount", int'(WCOUNT), 0);
        step(1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 2000; i++) begin
            if (((m_w - m_r + PMOD) % PMOD) > 0 && ($urandom_range(0, 99) < 45))
                m_r = (m_r + 1) % PMOD;
            step(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 9) == 0), "rand");
            if (i == 1000) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
